// File: rtl/instr_aligner.sv
// Instruction aligner: turns a queue of word-aligned fetch words into one instruction per cycle.
// Macro ALIGNER_RVC_EN enables halfword PCs and 16-bit compressed instructions.
module instr_aligner #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] in_word_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_instr_o,
  output logic [XLEN-1:0] out_pc_o,
  output logic            out_is_comp_o,
  output logic            out_misalign_o
);

  localparam int unsigned     PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CW        = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] word_q [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] exp_pc_q, exp_pc_d;

  logic [XLEN-1:0] word0_s;
  logic [XLEN-1:0] pc0_s;
  logic [XLEN-1:0] instr_s;
  logic [XLEN-1:0] mis_pc_s;
  logic            hoff_s;
  logic            is_comp_s;
  logic            run_s;
  logic            mis_valid_s;
  logic            in_fire_s;
  logic            push_s;
  logic            pop_s;
  logic            out_valid_s;
  logic            out_fire_s;

  assign word0_s    = word_q[rd_ptr_q];
  assign pc0_s      = pc_q[rd_ptr_q];
  assign in_ready_o = (count_q < CW'(DEPTH)) | flush_i;
  assign in_fire_s  = in_valid_i & in_ready_o;
  assign push_s     = in_fire_s & ~flush_i & run_s & (in_pc_i == exp_pc_q);
  assign out_fire_s = out_valid_s & out_ready_i;

`ifdef ALIGNER_RVC_EN
  logic        hoff_q, hoff_d;
  logic [15:0] head_hw_s;
  logic [XLEN-1:0] word1_s;
  logic        unused_rpc0_s;

  function automatic logic is_rvc(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

  assign unused_rpc0_s = redirect_pc_i[0];
  assign word1_s       = word_q[rd_ptr_q + PW'(1)];
  assign hoff_s        = hoff_q;
  assign head_hw_s     = hoff_q ? word0_s[31:16] : word0_s[15:0];
  assign is_comp_s     = is_rvc(head_hw_s);
  assign run_s         = 1'b1;
  assign mis_valid_s   = 1'b0;
  assign mis_pc_s      = '0;

  always_comb begin
    instr_s = word0_s;
    if (is_comp_s) begin
      instr_s = {16'h0000, head_hw_s};
    end else if (hoff_q) begin
      instr_s = {word1_s[15:0], word0_s[31:16]};
    end else begin
      instr_s = word0_s;
    end
  end

  // A compressed instruction in the low half only advances hoff; the word is freed once fully used.
  always_comb begin
    hoff_d = hoff_q;
    pop_s  = 1'b0;
    if (flush_i) begin
      hoff_d = redirect_pc_i[1];
      pop_s  = 1'b0;
    end else if (out_fire_s) begin
      if (is_comp_s) begin
        hoff_d = ~hoff_q;
        pop_s  = hoff_q;
      end else begin
        hoff_d = hoff_q;
        pop_s  = 1'b1;
      end
    end else begin
      hoff_d = hoff_q;
      pop_s  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hoff_q <= 1'b0;
    end else begin
      hoff_q <= hoff_d;
    end
  end
`else
  typedef enum logic {ST_RUN = 1'b0, ST_MISALIGN = 1'b1} state_e;

  state_e          state_q, state_d;
  logic            mis_done_q, mis_done_d;
  logic [XLEN-1:0] mis_pc_q, mis_pc_d;

  assign hoff_s      = 1'b0;
  assign is_comp_s   = 1'b0;
  assign instr_s     = word0_s;
  assign run_s       = (state_q == ST_RUN);
  assign mis_valid_s = (state_q == ST_MISALIGN) & ~mis_done_q;
  assign mis_pc_s    = mis_pc_q;
  assign pop_s       = out_fire_s & run_s;

  // A redirect to a halfword PC cannot be fetched without RVC: report it once, then wait for a flush.
  always_comb begin
    state_d    = state_q;
    mis_done_d = mis_done_q;
    mis_pc_d   = mis_pc_q;
    case (state_q)
      ST_RUN: begin
        if (flush_i && redirect_pc_i[1]) begin
          state_d    = ST_MISALIGN;
          mis_done_d = 1'b0;
          mis_pc_d   = redirect_pc_i;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MISALIGN: begin
        if (flush_i) begin
          state_d    = redirect_pc_i[1] ? ST_MISALIGN : ST_RUN;
          mis_done_d = 1'b0;
          mis_pc_d   = redirect_pc_i;
        end else if (out_fire_s) begin
          mis_done_d = 1'b1;
        end else begin
          mis_done_d = mis_done_q;
        end
      end
      default: begin
        state_d    = ST_RUN;
        mis_done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      mis_done_q <= 1'b0;
      mis_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      mis_done_q <= mis_done_d;
      mis_pc_q   <= mis_pc_d;
    end
  end
`endif

  // A 32-bit instruction starting in the upper half needs the following word as well.
  always_comb begin
    out_valid_s = 1'b0;
    if (flush_i) begin
      out_valid_s = 1'b0;
    end else if (mis_valid_s) begin
      out_valid_s = 1'b1;
    end else if (run_s) begin
      if (is_comp_s || !hoff_s) begin
        out_valid_s = (count_q >= CW'(1));
      end else begin
        out_valid_s = (count_q >= CW'(2));
      end
    end else begin
      out_valid_s = 1'b0;
    end
  end

  assign out_valid_o = out_valid_s;

  always_comb begin
    out_instr_o    = NOP_INSTR;
    out_pc_o       = '0;
    out_is_comp_o  = 1'b0;
    out_misalign_o = 1'b0;
    if (out_valid_s && mis_valid_s) begin
      out_pc_o       = mis_pc_s;
      out_misalign_o = 1'b1;
    end else if (out_valid_s) begin
      out_instr_o   = instr_s;
      out_pc_o      = pc0_s + {{(XLEN-2){1'b0}}, hoff_s, 1'b0};
      out_is_comp_o = is_comp_s;
    end else begin
      out_instr_o = NOP_INSTR;
    end
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    exp_pc_d = exp_pc_q;
    if (flush_i) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      exp_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        exp_pc_d = exp_pc_q + XLEN'(4);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      exp_pc_q <= RESET_PC;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      exp_pc_q <= exp_pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (push_s) begin
      word_q[wr_ptr_q] <= in_word_i;
      pc_q[wr_ptr_q]   <= in_pc_i;
    end
  end

  instr_aligner_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .count_i (count_q)
  );

endmodule

// Queue occupancy must never wrap in either direction.
module instr_aligner_chk #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = 2
) (
  input logic          clk,
  input logic          rst_n,
  input logic          flush_i,
  input logic          push_i,
  input logic          pop_i,
  input logic [CW-1:0] count_i
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (!flush_i && push_i && !pop_i) |-> (count_i < CW'(DEPTH)));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    (!flush_i && pop_i) |-> (count_i != '0));

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count_i <= CW'(DEPTH));

endmodule

// File: tb/tb_instr_aligner.sv
// Self-checking bench for instr_aligner: directed vector tables, reset checks and a randomized run
// against a halfword-stream reference model.
module tb_instr_aligner;

  localparam int unsigned    DEPTH = 2;
  localparam logic [31:0]    NOP   = 32'h0000_0013;
`ifdef ALIGNER_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_word_i = '0;
  logic [31:0] in_pc_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_instr_o;
  logic [31:0] out_pc_o;
  logic        out_is_comp_o;
  logic        out_misalign_o;

  instr_aligner #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush_i),
    .redirect_pc_i  (redirect_pc_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_word_i      (in_word_i),
    .in_pc_i        (in_pc_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_instr_o    (out_instr_o),
    .out_pc_o       (out_pc_o),
    .out_is_comp_o  (out_is_comp_o),
    .out_misalign_o (out_misalign_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        f;
    logic [31:0] rpc;
    logic        iv;
    logic [31:0] iw;
    logic [31:0] ipc;
    logic        ordy;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] epc;
    logic        ec;
    logic        em;
    logic        erdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic f, input logic [31:0] rpc, input logic iv,
                              input logic [31:0] iw, input logic [31:0] ipc, input logic ordy,
                              input logic ev, input logic [31:0] ei, input logic [31:0] epc,
                              input logic ec, input logic em, input logic erdy);
    vec_t v;
    v.f = f; v.rpc = rpc; v.iv = iv; v.iw = iw; v.ipc = ipc; v.ordy = ordy;
    v.ev = ev; v.ei = ei; v.epc = epc; v.ec = ec; v.em = em; v.erdy = erdy;
    return v;
  endfunction

  task automatic drive(input logic f, input logic [31:0] rpc, input logic iv,
                       input logic [31:0] iw, input logic [31:0] ipc, input logic ordy);
    flush_i = f; redirect_pc_i = rpc; in_valid_i = iv; in_word_i = iw; in_pc_i = ipc;
    out_ready_i = ordy;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    drive(v.f, v.rpc, v.iv, v.iw, v.ipc, v.ordy);
    #1;
    check($sformatf("vec%0d valid", idx), 32'(out_valid_o), 32'(v.ev));
    check($sformatf("vec%0d ready", idx), 32'(in_ready_o), 32'(v.erdy));
    if (v.ev) begin
      check($sformatf("vec%0d instr", idx), out_instr_o, v.ei);
      check($sformatf("vec%0d pc", idx), out_pc_o, v.epc);
      check($sformatf("vec%0d comp", idx), 32'(out_is_comp_o), 32'(v.ec));
      check($sformatf("vec%0d misalign", idx), 32'(out_misalign_o), 32'(v.em));
    end
  endtask

  // Reference model: a stream of pending halfwords, each tagged with its own PC.
  typedef struct {
    logic [15:0] hw;
    logic [31:0] pc;
  } hw_t;

  hw_t         hq[$];
  logic [31:0] m_exp_pc = 32'h8000_0000;
  bit          m_skip = 1'b0;
  bit          m_mis = 1'b0;
  bit          m_mis_pend = 1'b0;
  logic [31:0] m_mis_pc = '0;

  function automatic int words_held();
    if (hq.size() == 0) return 0;
    return hq[0].pc[1] ? (hq.size() + 1) / 2 : hq.size() / 2;
  endfunction

  logic        r_f, r_iv, r_ordy;
  logic [31:0] r_rpc, r_iw, r_ipc;
  logic        e_v, e_c, e_m, e_rdy;
  logic [31:0] e_i, e_pc;

  initial begin
    // Reset values, both while held and just after release.
    repeat (2) @(negedge clk);
    #1;
    check("rst valid", 32'(out_valid_o), 32'd0);
    check("rst ready", 32'(in_ready_o), 32'd1);
    check("rst instr", out_instr_o, NOP);
    check("rst pc", out_pc_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-rst valid", 32'(out_valid_o), 32'd0);
    check("post-rst instr", out_instr_o, NOP);
    check("post-rst pc", out_pc_o, 32'd0);
    check("post-rst comp", 32'(out_is_comp_o), 32'd0);
    check("post-rst misalign", 32'(out_misalign_o), 32'd0);
    check("post-rst ready", 32'(in_ready_o), 32'd1);

    if (RVC) begin
      vecs.push_back(mk(1, 32'h8000_0000, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 32'h00A0_0093, 32'h8000_0000, 1,  0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, 32'h00A0_0093, 32'h8000_0000, 0, 0, 1));
      vecs.push_back(mk(1, 32'h8000_0000, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 32'h4505_4585, 32'h8000_0000, 0,  0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, 32'h0000_4585, 32'h8000_0000, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 32'h0000_4505, 32'h8000_0002, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, 32'h0000_4505, 32'h8000_0002, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 32'h8000_0002, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 32'h0093_1234, 32'h8000_0000, 1,  0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 32'h5678_00A0, 32'h8000_0004, 1,  0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 32'h00A0_0093, 32'h8000_0002, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, 32'h00A0_0093, 32'h8000_0002, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, 32'h0000_5678, 32'h8000_0006, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1));
    end else begin
      vecs.push_back(mk(1, 32'h8000_0000, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 32'h00A0_0093, 32'h8000_0000, 1,  0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1, 32'h00A0_0093, 32'h8000_0000, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 32'h1111_1113, 32'h8000_0004, 1,  1, 32'h00A0_0093, 32'h8000_0000, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 32'h2222_2213, 32'h8000_0008, 0,  1, 32'h1111_1113, 32'h8000_0004, 0, 0, 1));
      vecs.push_back(mk(1, 32'h8000_0100, 1, 32'h3333_3313, 32'h8000_000C, 1,  0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 32'h4444_4413, 32'h8000_0008, 1,  0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 32'h5555_5513, 32'h8000_0100, 1,  0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, 32'h5555_5513, 32'h8000_0100, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 32'h6666_6613, 32'h8000_0104, 0,  0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 32'h7777_7713, 32'h8000_0108, 0,  1, 32'h6666_6613, 32'h8000_0104, 0, 0, 1));
      for (int i = 0; i < 5; i++)
        vecs.push_back(mk(0, 0, 1, 32'h8888_8813, 32'h8000_010C, 0,  1, 32'h6666_6613, 32'h8000_0104, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 32'h8888_8813, 32'h8000_010C, 1,  1, 32'h6666_6613, 32'h8000_0104, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 32'h8888_8813, 32'h8000_010C, 1,  1, 32'h7777_7713, 32'h8000_0108, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, 32'h8888_8813, 32'h8000_010C, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 32'h8000_0002, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 32'h9999_9913, 32'h8000_0000, 0,  1, NOP, 32'h8000_0002, 0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, NOP, 32'h8000_0002, 0, 1, 1));
      vecs.push_back(mk(0, 0, 1, 32'hAAAA_AA13, 32'h8000_0000, 1,  0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 32'h8000_0200, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 32'hBBBB_BB13, 32'h8000_0200, 1,  0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1,  1, 32'hBBBB_BB13, 32'h8000_0200, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1));
    end
    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

    // Asynchronous reset while an instruction is being presented.
    @(negedge clk);
    drive(1, 32'h8000_0000, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 1, 32'hCAFE_0013, 32'h8000_0000, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("pre-arst valid", 32'(out_valid_o), 32'd1);
    check("pre-arst instr", out_instr_o, 32'hCAFE_0013);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst valid", 32'(out_valid_o), 32'd0);
    check("arst ready", 32'(in_ready_o), 32'd1);
    check("arst instr", out_instr_o, NOP);
    check("arst pc", out_pc_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the reference model; cycle 0 flushes to synchronise it.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      r_f = (c == 0) || ($urandom_range(99) < 3);
      if (RVC) r_rpc = 32'h8000_0000 + 32'($urandom_range(63)) * 32'd2;
      else     r_rpc = 32'h8000_0000 + 32'($urandom_range(63)) * 32'd4 +
                       (($urandom_range(7) == 0) ? 32'd2 : 32'd0);
      r_iv = ($urandom_range(3) != 0);
      case ($urandom_range(9))
        0:       r_ipc = m_exp_pc - 32'd4;
        1:       r_ipc = m_exp_pc + 32'd4;
        default: r_ipc = m_exp_pc;
      endcase
      r_iw = $urandom;
      if ($urandom_range(1) == 1) r_iw[1:0] = 2'b11;
      r_ordy = ($urandom_range(3) != 0);
      drive(r_f, r_rpc, r_iv, r_iw, r_ipc, r_ordy);
      #1;

      e_rdy = (words_held() < DEPTH) || r_f;
      e_v = 1'b0; e_i = NOP; e_pc = '0; e_c = 1'b0; e_m = 1'b0;
      if (!r_f) begin
        if (m_mis) begin
          if (m_mis_pend) begin
            e_v = 1'b1; e_pc = m_mis_pc; e_m = 1'b1;
          end
        end else if (hq.size() > 0) begin
          e_c = RVC && (hq[0].hw[1:0] != 2'b11);
          e_pc = hq[0].pc;
          if (e_c) begin
            e_v = 1'b1; e_i = {16'h0000, hq[0].hw};
          end else if (hq.size() >= 2) begin
            e_v = 1'b1; e_i = {hq[1].hw, hq[0].hw};
          end
        end
      end

      check($sformatf("rnd%0d valid", c), 32'(out_valid_o), 32'(e_v));
      check($sformatf("rnd%0d ready", c), 32'(in_ready_o), 32'(e_rdy));
      if (e_v) begin
        check($sformatf("rnd%0d instr", c), out_instr_o, e_i);
        check($sformatf("rnd%0d pc", c), out_pc_o, e_pc);
        check($sformatf("rnd%0d comp", c), 32'(out_is_comp_o), 32'(e_c));
        check($sformatf("rnd%0d misalign", c), 32'(out_misalign_o), 32'(e_m));
      end

      if (r_f) begin
        hq.delete();
        m_exp_pc   = {r_rpc[31:2], 2'b00};
        m_skip     = RVC && r_rpc[1];
        m_mis      = !RVC && r_rpc[1];
        m_mis_pend = m_mis;
        m_mis_pc   = r_rpc;
      end else begin
        if (e_v && r_ordy) begin
          if (m_mis) begin
            m_mis_pend = 1'b0;
          end else begin
            void'(hq.pop_front());
            if (!e_c) void'(hq.pop_front());
          end
        end
        if (r_iv && e_rdy && !m_mis && (r_ipc == m_exp_pc)) begin
          if (!m_skip) hq.push_back('{hw: r_iw[15:0], pc: r_ipc});
          hq.push_back('{hw: r_iw[31:16], pc: r_ipc + 32'd2});
          m_skip   = 1'b0;
          m_exp_pc = m_exp_pc + 32'd4;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
